// File: rtl/piezo_pkg.sv
// ============================================================================
// piezo_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the piezo tone generator:
//   - HALF_TBL : half-period of each note, in cycles of a 1 MHz clock
//                (C4, D4, E4, F4, G4, A4, B4, C5)
//   - state_t  : tone FSM state encoding
//   - CNT_W    : width of the half-period limit and counter, sized for the
//                longest note at the fastest legal clock (100 MHz)
// ============================================================================
package piezo_pkg;

    // Tone FSM states. SUSTAIN is only ever entered when the sustain
    // feature is compiled in.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        SUSTAIN = 2'd2,
        STOP    = 2'd3
    } state_t;

    // Half-period table at 1 MHz, indexed by note number.
    localparam logic [10:0] HALF_TBL [8] = '{
        11'd1911, 11'd1703, 11'd1517, 11'd1432,
        11'd1276, 11'd1136, 11'd1012, 11'd956
    };

    // Width needed to hold the longest half-period at the given clock rate,
    // plus one bit of headroom.
    function automatic int calc_cnt_w(input int max_mhz);
        return $clog2(1911 * max_mhz) + 1;
    endfunction

    localparam int CNT_W = calc_cnt_w(100);

endpackage

// File: rtl/piezo_note_sel.sv
// ============================================================================
// piezo_note_sel
// ----------------------------------------------------------------------------
// Combinational note selection. Picks the highest set key bit (which is the
// lowest note), and computes the half-period terminal count for that note at
// the configured clock rate and octave shift.
//
// Parameters:
//   CLK_MHZ  system clock in MHz (1..100)
//   N_KEYS   number of key inputs (1..8)
//
// Ports:
//   key_i    registered key vector; key_i[N_KEYS-1] is note 0
//   oct_i    registered octave shift 0..3
//   valid_o  at least one key is pressed
//   note_o   index of the winning note (0 when no key is pressed)
//   lim_o    half-period terminal count: ((HALF_TBL*CLK_MHZ) >> oct) - 1
// ============================================================================
module piezo_note_sel
    import piezo_pkg::*;
#(
    parameter int CLK_MHZ = 1,
    parameter int N_KEYS  = 8
) (
    input  logic [N_KEYS-1:0] key_i,
    input  logic [1:0]        oct_i,
    output logic              valid_o,
    output logic [2:0]        note_o,
    output logic [CNT_W-1:0]  lim_o
);

    logic [CNT_W-1:0] scaled;

    // Priority encoder: scanning upward, the last set bit seen is the highest
    // one, so it overrides any lower bits and the lowest note wins.
    always_comb begin
        valid_o = 1'b0;
        note_o  = 3'd0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (key_i[i]) begin
                valid_o = 1'b1;
                note_o  = 3'(N_KEYS - 1 - i);
            end
        end
    end

    // Scale the 1 MHz half-period to the real clock, then halve it once per
    // octave step. The shortest possible result (956 >> 3) is well above 1,
    // so the minus-one can never underflow.
    always_comb begin
        scaled = CNT_W'(HALF_TBL[note_o]) * CNT_W'(CLK_MHZ);
        lim_o  = (scaled >> oct_i) - CNT_W'(1);
    end

endmodule

// File: rtl/piezo_tone_gen.sv
// ============================================================================
// piezo_tone_gen
// ----------------------------------------------------------------------------
// Square-wave piezo driver for the highest-priority pressed key, with octave
// shift, clock-rate scaling, note changes that only take effect on a
// half-period boundary, and an optional release sustain.
//
// Build option:
//   PIEZO_SUSTAIN_EN  when defined, releasing all keys keeps the tone going
//                     for SUSTAIN_CYC cycles before stopping; when undefined,
//                     release goes straight to the stop phase.
//
// Parameters:
//   CLK_MHZ      system clock in MHz (1..100)
//   N_KEYS       number of key inputs (1..8)
//   SUSTAIN_CYC  release sustain length in cycles (sustain builds only)
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   key      key vector; key[N_KEYS-1] = note 0 (C4) ... key[0] = note N_KEYS-1
//   octave   upward octave shift 0..3
//   piezo    square-wave drive
//   playing  high while a tone is active (PLAY / SUSTAIN / STOP)
//   note     note currently sounding, 0 when idle
// ============================================================================
module piezo_tone_gen
    import piezo_pkg::*;
#(
    parameter int CLK_MHZ     = 1,
    parameter int N_KEYS      = 8,
    parameter int SUSTAIN_CYC = 200000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key,
    input  logic [1:0]        octave,
    output logic              piezo,
    output logic              playing,
    output logic [2:0]        note
);

    logic [N_KEYS-1:0] key_q;
    logic [1:0]        oct_q;
    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cur_lim_q;
    logic [2:0]        note_q;
    logic              piezo_q;
    logic              playing_q;

    logic              selValid;
    logic [2:0]        selNote;
    logic [CNT_W-1:0]  selLim;

    logic              toggle;
    logic [CNT_W-1:0]  cnt_d;

`ifdef PIEZO_SUSTAIN_EN
    localparam int SUS_W = (SUSTAIN_CYC > 1) ? $clog2(SUSTAIN_CYC) : 1;
    logic [SUS_W-1:0]  sus_q;
`else
    logic              unusedSustain;
    assign unusedSustain = ^SUSTAIN_CYC;
`endif

    piezo_note_sel #(
        .CLK_MHZ (CLK_MHZ),
        .N_KEYS  (N_KEYS)
    ) u_note_sel (
        .key_i   (key_q),
        .oct_i   (oct_q),
        .valid_o (selValid),
        .note_o  (selNote),
        .lim_o   (selLim)
    );

    // The toggle event ends the current half-period. The counter restarts
    // there and otherwise just advances; it never runs past cur_lim_q.
    always_comb begin
        toggle = (cnt_q == cur_lim_q);
        cnt_d  = toggle ? '0 : cnt_q + CNT_W'(1);
    end

    // Input registers plus the tone FSM. A newly selected note or octave is
    // only copied into cur_lim_q/note_q on a toggle event, so a half-period
    // already in progress always finishes at its original length. In STOP the
    // final toggle event forces piezo low instead of toggling, so the pin
    // never goes high on the way back to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q     <= '0;
            oct_q     <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_lim_q <= '0;
            note_q    <= 3'd0;
            piezo_q   <= 1'b0;
            playing_q <= 1'b0;
`ifdef PIEZO_SUSTAIN_EN
            sus_q     <= '0;
`endif
        end else begin
            key_q <= key;
            oct_q <= octave;

            case (state_q)
                IDLE: begin
                    piezo_q <= 1'b0;
                    cnt_q   <= '0;
                    if (selValid) begin
                        state_q   <= PLAY;
                        cur_lim_q <= selLim;
                        note_q    <= selNote;
                        playing_q <= 1'b1;
                    end
                end

                PLAY: begin
                    cnt_q <= cnt_d;
                    if (toggle) begin
                        piezo_q <= ~piezo_q;
                        if (selValid) begin
                            cur_lim_q <= selLim;
                            note_q    <= selNote;
                        end
                    end
                    if (!selValid) begin
`ifdef PIEZO_SUSTAIN_EN
                        state_q <= SUSTAIN;
                        sus_q   <= SUS_W'(SUSTAIN_CYC - 1);
`else
                        state_q <= STOP;
`endif
                    end
                end

`ifdef PIEZO_SUSTAIN_EN
                SUSTAIN: begin
                    cnt_q <= cnt_d;
                    if (toggle) begin
                        piezo_q <= ~piezo_q;
                        if (selValid) begin
                            cur_lim_q <= selLim;
                            note_q    <= selNote;
                        end
                    end
                    if (selValid) begin
                        state_q <= PLAY;
                    end else if (sus_q == '0) begin
                        state_q <= STOP;
                    end else begin
                        sus_q <= sus_q - SUS_W'(1);
                    end
                end
`endif

                STOP: begin
                    cnt_q <= cnt_d;
                    if (selValid) begin
                        state_q <= PLAY;
                        if (toggle) begin
                            piezo_q   <= ~piezo_q;
                            cur_lim_q <= selLim;
                            note_q    <= selNote;
                        end
                    end else if (toggle) begin
                        piezo_q   <= 1'b0;
                        state_q   <= IDLE;
                        playing_q <= 1'b0;
                        note_q    <= 3'd0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign piezo   = piezo_q;
    assign playing = playing_q;
    assign note    = note_q;

endmodule

// File: tb/tb_piezo_tone_gen.sv
// ============================================================================
// tb_piezo_tone_gen
// ----------------------------------------------------------------------------
// Directed bench for piezo_tone_gen. One instance at 1 MHz exercises the
// timing, note change, release and reset behaviour; a second instance at
// 4 MHz checks clock scaling, octave shift and key priority.
// ============================================================================
module tb_piezo_tone_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] key = 8'h00;
    logic [1:0] octave = 2'd0;
    logic       piezo;
    logic       playing;
    logic [2:0] note;

    logic [7:0] key4 = 8'h00;
    logic [1:0] oct4 = 2'd0;
    logic       piezo4;
    logic       playing4;
    logic [2:0] note4;

    int cyc = 0;
    int riseCount = 0;
    logic prevPiezo = 1'b0;
    int checkCount = 0;
    int passCount = 0;

    piezo_tone_gen #(
        .CLK_MHZ     (1),
        .N_KEYS      (8),
        .SUSTAIN_CYC (5000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key     (key),
        .octave  (octave),
        .piezo   (piezo),
        .playing (playing),
        .note    (note)
    );

    piezo_tone_gen #(
        .CLK_MHZ     (4),
        .N_KEYS      (8),
        .SUSTAIN_CYC (5000)
    ) dut4 (
        .clk     (clk),
        .reset   (reset),
        .key     (key4),
        .octave  (oct4),
        .piezo   (piezo4),
        .playing (playing4),
        .note    (note4)
    );

    // Free-running clock and a count of rising edges, so edge times can be
    // expressed as edge numbers.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count rising edges of the main piezo output, seen at the falling clock.
    always @(negedge clk) begin
        if (piezo === 1'b1 && prevPiezo === 1'b0) riseCount++;
        prevPiezo = piezo;
    end

    // One comparison: count it, and report it if it does not match.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    // Drive key/octave of the main instance (called at a falling edge) and
    // return the number of the rising edge that will sample them.
    task automatic applyStimulus(input logic [7:0] k, input logic [1:0] o, output int e0);
        key    = k;
        octave = o;
        e0     = cyc + 1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for the selected piezo output to reach val; returns the rising
    // edge number that produced it.
    task automatic waitPiezo(input int which, input logic val, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (((which == 0) ? piezo : piezo4) === val) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) checkOutput("piezo edge timeout", 0, 1);
    endtask

    task automatic waitPlaying(input logic val, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (playing === val) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) checkOutput("playing timeout", 0, 1);
    endtask

    initial begin
        int e0, r1, f1, r2, f2, r3, f3, r5, t, rc, rs;

        // Reset state
        @(negedge clk);
        reset = 1'b1;
        idleCycles(2);
        checkOutput("reset piezo", piezo, 0);
        checkOutput("reset playing", playing, 0);
        checkOutput("reset note", note, 0);
        reset = 1'b0;
        idleCycles(3);

        // C4 held: first rise at E0+1912, half 1911, period 3822
        applyStimulus(8'h80, 2'd0, e0);
        @(negedge clk);
        checkOutput("playing at E0", playing, 0);
        @(negedge clk);
        checkOutput("playing at E1", playing, 1);
        checkOutput("note C4", note, 0);
        waitPiezo(0, 1'b1, 3000, r1);
        checkOutput("first rise C4", r1 - e0, 1912);
        waitPiezo(0, 1'b0, 3000, f1);
        checkOutput("high half C4", f1 - r1, 1911);
        waitPiezo(0, 1'b1, 3000, r2);
        checkOutput("period C4", r2 - r1, 3822);

        // Switch to C5 mid half-period: old half completes, then 956
        idleCycles(500);
        applyStimulus(8'h01, 2'd0, e0);
        waitPiezo(0, 1'b0, 3000, f2);
        checkOutput("old half completes", f2 - r2, 1911);
        checkOutput("note C5", note, 7);
        waitPiezo(0, 1'b1, 3000, r3);
        checkOutput("low half C5", r3 - f2, 956);
        waitPiezo(0, 1'b0, 3000, f3);
        checkOutput("high half C5", f3 - r3, 956);
        waitPiezo(0, 1'b1, 3000, r5);
        idleCycles(100);

`ifndef PIEZO_SUSTAIN_EN
        // Release while high: piezo falls at the next toggle, then idle
        applyStimulus(8'h00, 2'd0, e0);
        waitPiezo(0, 1'b0, 3000, t);
        checkOutput("stop fall time", t - r5, 956);
        checkOutput("playing after stop", playing, 0);
        checkOutput("note after stop", note, 0);
        rc = riseCount;
        idleCycles(2000);
        checkOutput("idle stays silent", riseCount - rc, 0);

        // Release while low: no rise, playing falls at next toggle event
        applyStimulus(8'h01, 2'd0, e0);
        waitPiezo(0, 1'b1, 3000, r1);
        checkOutput("first rise C5", r1 - e0, 957);
        waitPiezo(0, 1'b0, 3000, f1);
        idleCycles(100);
        rc = riseCount;
        applyStimulus(8'h00, 2'd0, e0);
        waitPlaying(1'b0, 3000, t);
        checkOutput("low release stop time", t - f1, 956);
        checkOutput("no rise in stop", riseCount - rc, 0);
        checkOutput("piezo low in idle", piezo, 0);
`else
        // Release with sustain: toggling continues ~5000 cycles, then stops
        applyStimulus(8'h00, 2'd0, e0);
        rc = riseCount;
        idleCycles(3000);
        checkOutput("sustain playing", playing, 1);
        checkOutput("sustain toggles", (riseCount - rc >= 1) ? 1 : 0, 1);
        waitPlaying(1'b0, 8000, t);
        checkOutput("sustain length window",
                    (t >= e0 + 1 + 5000 && t <= e0 + 1 + 5000 + 956) ? 1 : 0, 1);
        checkOutput("piezo low after sustain", piezo, 0);

        // Re-press during sustain: tone carries on without stopping
        applyStimulus(8'h01, 2'd0, e0);
        waitPiezo(0, 1'b1, 3000, r1);
        checkOutput("first rise C5", r1 - e0, 957);
        applyStimulus(8'h00, 2'd0, e0);
        idleCycles(2000);
        applyStimulus(8'h01, 2'd0, e0);
        rc = riseCount;
        idleCycles(6000);
        checkOutput("re-press playing", playing, 1);
        checkOutput("re-press toggles", (riseCount - rc >= 2) ? 1 : 0, 1);
        applyStimulus(8'h00, 2'd0, e0);
        waitPlaying(1'b0, 8000, t);
`endif

        // 4 MHz instance, octave 2, keys 6/1/0 pressed: bit 6 wins (note 1)
        key4 = 8'b0100_0011;
        oct4 = 2'd2;
        e0   = cyc + 1;
        waitPiezo(1, 1'b1, 4000, r1);
        checkOutput("4MHz first rise", r1 - e0, 1704);
        checkOutput("4MHz priority note", note4, 1);
        waitPiezo(1, 1'b0, 4000, f1);
        checkOutput("4MHz half period", f1 - r1, 1703);
        key4 = 8'h00;

        // Reset mid-tone with piezo high, key still held
        applyStimulus(8'h01, 2'd0, e0);
        waitPiezo(0, 1'b1, 3000, r1);
        idleCycles(10);
        reset = 1'b1;
        @(negedge clk);
        rs = cyc;
        checkOutput("mid reset piezo", piezo, 0);
        checkOutput("mid reset playing", playing, 0);
        checkOutput("mid reset note", note, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("playing R+1", playing, 0);
        @(negedge clk);
        checkOutput("playing R+2", playing, 1);
        waitPiezo(0, 1'b1, 3000, r1);
        checkOutput("rise after reset", r1 - rs, 958);

        // Octave up mid half-period: takes effect after the next toggle
        idleCycles(50);
        applyStimulus(8'h01, 2'd1, e0);
        waitPiezo(0, 1'b0, 3000, f1);
        checkOutput("half before octave", f1 - r1, 956);
        waitPiezo(0, 1'b1, 3000, r2);
        checkOutput("half after octave", r2 - f1, 478);

        applyStimulus(8'h00, 2'd0, e0);
        waitPlaying(1'b0, 10000, t);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/piezo_tone_gen.md
# piezo_tone_gen

Parametrised successor to the single-octave piezo driver. Generates a square wave on a piezo pin for the highest-priority pressed key. Adds octave shift, clock-rate scaling, glitch-free note changes, and an optional release sustain. Sits between the key-scan/debounce logic and the board buzzer pin.

## Interface

Parameters:
- CLK_MHZ, 1: system clock in MHz, legal range 1..100; scales all half-periods.
- N_KEYS, 8: number of key inputs, legal range 1..8.
- SUSTAIN_CYC, 200000: number of cycles the tone continues after release. Used only with PIEZO_SUSTAIN_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- key  in  N_KEYS  one-hot-ish key vector; key[N_KEYS-1] = note 0 (C4) … key[0] = note N_KEYS-1.
- octave  in  2  upward octave shift 0..3.
- piezo  out  1  square-wave drive.
- playing  out  1  high in PLAY/SUSTAIN/STOP.
- note  out  3  index of note currently sounding; 0 when idle.

## Operation

- Input register: key and octave are sampled into key_q/oct_q every edge; the FSM uses only the registered copies.
- Priority: highest set bit of key_q wins (lowest note). key_q == 0 means released.
- Half-period limit: lim = ((HALF_TBL[n] * CLK_MHZ) >> oct_q) − 1, where HALF_TBL = 1911,1703,1517,1432,1276,1136,1012,956 cycles at 1 MHz. Compute it unsigned at width clog2(1911*100)+1. The counter has the same width and never wraps past lim.
- Toggle event: cnt == lim → cnt ← 0, piezo ← ~piezo; otherwise cnt ← cnt + 1.
- FSM states: IDLE, PLAY, SUSTAIN, STOP.
  - IDLE: piezo = 0, cnt = 0. If a key is valid → PLAY, cur_lim/note loaded, cnt ← 0.
  - PLAY: counts and toggles. A new note or octave is latched into cur_lim/note only on a toggle event, never mid half-period. On release → SUSTAIN if PIEZO_SUSTAIN_EN, else → STOP.
  - SUSTAIN: keeps toggling on the last note while a sustain counter counts SUSTAIN_CYC − 1 down to 0. A valid key → PLAY, using the normal change rule. Expiry → STOP.
  - STOP: keeps counting to the next toggle event. At that event, if piezo == 1 it drives 0; if piezo == 0 it does not toggle. Then → IDLE.
  - In STOP a new key → PLAY (no restart; the change rule applies).
- Simultaneous events: a release and a toggle in the same cycle → the toggle executes and the state moves to SUSTAIN/STOP. A key change and a toggle in the same cycle → the new lim takes effect for the next half-period.
- Reset values: piezo 0, playing 0, note 0, cnt 0, state IDLE, sustain counter 0.
- A reset mid-operation forces all of the above at the next edge, regardless of state.

## Timing

- Key sampled at edge E0 → PLAY at E1 with cnt = 0 → first rising edge of piezo at E0 + lim + 2.
- Half-period = lim + 1 cycles exactly; the period is 2·(lim + 1).
- playing rises at E1. It falls on the edge that enters IDLE.
- Note/octave change latency: 1 input-register cycle plus up to lim + 1 cycles, waiting for the toggle event.
- piezo is always low in IDLE. No runt pulses shorter than the smaller of the old and new half-periods.

## Configuration

- PIEZO_SUSTAIN_EN defined: the SUSTAIN state and SUSTAIN_CYC counter are present; release → SUSTAIN.
- PIEZO_SUSTAIN_EN undefined: no SUSTAIN state and no counter logic; release → STOP directly; SUSTAIN_CYC is ignored.

## Structure

- Package piezo_pkg contains:
  - HALF_TBL constant array (8 × 11 bit);
  - state enum {IDLE, PLAY, SUSTAIN, STOP};
  - CNT_W localparam function.
- Sub-module piezo_note_sel: combinational priority encoder plus lim computation. Output valid, note, lim. Instantiated once.
- Top: input registers, FSM, half-period counter, sustain counter.

## Test plan

- CLK_MHZ=1, octave=0, key=8'b1000_0000 held: piezo first rises 1912 cycles after the sampling edge; period 3822; note=0; playing=1.
- Switch to key=8'b0000_0001 mid half-period: current half-period completes at 1911 cycles, then half-periods are 956; no pulse shorter than 956 cycles.
- octave=2, CLK_MHZ=4, key=8'b0100_0000: lim = (1703·4 >> 2) − 1 = 1702; half-period 1703 cycles.
- Without PIEZO_SUSTAIN_EN, release while piezo=1 → piezo falls at the next toggle, then IDLE; release while piezo=0 → stays 0, playing falls at the next toggle event.
- With PIEZO_SUSTAIN_EN, SUSTAIN_CYC=5000: release → toggling continues ≈5000 cycles, then STOP/IDLE. A re-press at cycle 2000 → PLAY and no stop.
- Assert reset for 1 cycle mid-tone with piezo=1 → next edge piezo=0, playing=0, note=0. With the key still held, PLAY resumes 2 edges after reset drops.
